msb_word_serializer: RTL and testbench

- Upstream stage for the serial mod-3 remainder/quotient FSM.
- Accepts a parallel W-bit word through a valid/ready handshake and emits it MSB-first, one bit per clock.
- Emits a one-cycle frame-clear strobe before each word; the downstream FSM uses it to return to its zero-remainder state.
- Flags the last bit of each word so the downstream output can be captured.

---
 rtl/msb_word_serializer_if.sv | 19 +
 rtl/msb_word_serializer.sv | 42 ++++
 tb/tb_msb_word_serializer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/msb_word_serializer_if.sv
// msb_word_serializer_if: word-load handshake and serial bit stream between a word source and the serializer
interface msb_word_serializer_if #(parameter int W = 8);
  logic         load_valid;
  logic [W-1:0] data_in;
  logic         load_ready;
  logic         frame_clr;
  logic         bit_out;
  logic         bit_valid;
  logic         last_bit;
  logic         busy;
  modport master (
    output load_valid, data_in,
    input  load_ready, frame_clr, bit_out, bit_valid, last_bit, busy
  );
  modport slave (
    input  load_valid, data_in,
    output load_ready, frame_clr, bit_out, bit_valid, last_bit, busy
  );
endinterface

// File: rtl/msb_word_serializer.sv
// msb_word_serializer: accepts a W-bit word and emits it MSB-first, preceded by a one-cycle frame-clear strobe
module msb_word_serializer #(
  parameter int W = 8
) (
  input logic                clk,
  input logic                rst,
  msb_word_serializer_if.slave s
);
  localparam int CW = $clog2(W);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_shift, is_last, acc;
  always_comb begin
    is_shift = state_q == SHIFT;
    is_last  = is_shift && cnt_q == '0;
    acc      = s.load_valid && (state_q == IDLE || is_last);
    state_d  = acc ? CLEAR : state_q == CLEAR ? SHIFT : (is_shift && !is_last) ? SHIFT : IDLE;
    shreg_d  = acc ? s.data_in : is_shift ? {shreg_q[W-2:0], 1'b0} : shreg_q;
    cnt_d    = state_q == CLEAR ? CW'(W - 1) : (is_shift && !is_last) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end
  assign s.load_ready = state_q == IDLE || is_last;
  assign s.frame_clr  = state_q == CLEAR;
  assign s.bit_out    = is_shift && shreg_q[W-1];
  assign s.bit_valid  = is_shift;
  assign s.last_bit   = is_last;
  assign s.busy       = state_q == CLEAR || is_shift;
endmodule

// File: tb/tb_msb_word_serializer.sv
// tb_msb_word_serializer: scoreboard bench for the MSB-first word serializer at W=8 and W=4
module tb_msb_word_serializer;
  typedef struct {
    logic [7:0] w;
    int         t;
  } txn_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  txn_t q8[$];
  txn_t q4[$];
  txn_t cur8, cur4;
  bit   act8 = 0, act4 = 0;
  int   n8 = 0, n4 = 0, r8 = 0;
  logic [7:0] quo8;
  msb_word_serializer_if #(.W(8)) i8 ();
  msb_word_serializer_if #(.W(4)) i4 ();
  msb_word_serializer #(.W(8)) u8 (.clk(clk), .rst(rst), .s(i8));
  msb_word_serializer #(.W(4)) u4 (.clk(clk), .rst(rst), .s(i4));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && i8.load_valid && i8.load_ready) q8.push_back('{i8.data_in, cyc});
    if (!rst && i4.load_valid && i4.load_ready) q4.push_back('{{4'h0, i4.data_in}, cyc});
  end
  always @(negedge clk) begin
    if (rst) begin
      act8 = 0;
      q8.delete();
    end else if (i8.frame_clr) begin
      chk("w8_clr_expected", q8.size() != 0, 1);
      if (q8.size() != 0) begin
        cur8 = q8.pop_front();
        chk("w8_clr_latency", cyc, cur8.t + 1);
      end
      chk("w8_clr_outs", {i8.busy, i8.bit_valid, i8.load_ready, i8.bit_out, i8.last_bit}, 5'b10000);
      act8 = 1;
      n8 = 0;
      r8 = 0;
      quo8 = '0;
    end else if (i8.bit_valid) begin
      chk("w8_bit_in_frame", act8, 1);
      chk("w8_bit_out", i8.bit_out, cur8.w[7-n8]);
      chk("w8_last_bit", i8.last_bit, n8 == 7);
      chk("w8_ready_mid", i8.load_ready, n8 == 7);
      chk("w8_busy", i8.busy, 1);
      chk("w8_bit_time", cyc, cur8.t + 2 + n8);
      quo8 = {quo8[6:0], (2 * r8 + int'(i8.bit_out)) >= 3};
      r8 = (2 * r8 + int'(i8.bit_out)) % 3;
      if (n8 == 7) begin
        chk("w8_quotient", quo8, cur8.w / 3);
        chk("w8_remainder", r8, cur8.w % 3);
        act8 = 0;
      end
      n8++;
    end else begin
      chk("w8_no_gap", act8, 0);
      chk("w8_idle_outs", {i8.busy, i8.load_ready, i8.bit_out, i8.last_bit}, 4'b0100);
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      act4 = 0;
      q4.delete();
    end else if (i4.frame_clr) begin
      chk("w4_clr_expected", q4.size() != 0, 1);
      if (q4.size() != 0) begin
        cur4 = q4.pop_front();
        chk("w4_clr_latency", cyc, cur4.t + 1);
      end
      act4 = 1;
      n4 = 0;
    end else if (i4.bit_valid) begin
      chk("w4_bit_in_frame", act4, 1);
      chk("w4_bit_out", i4.bit_out, cur4.w[3-n4]);
      chk("w4_last_bit", i4.last_bit, n4 == 3);
      chk("w4_bit_time", cyc, cur4.t + 2 + n4);
      if (n4 == 3) act4 = 0;
      n4++;
    end else begin
      chk("w4_no_gap", act4, 0);
      chk("w4_idle_outs", {i4.busy, i4.load_ready, i4.bit_out, i4.last_bit}, 4'b0100);
    end
  end
  task automatic wait_acc8();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (i8.load_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("w8_accept_timeout", 0, 1);
  endtask
  task automatic send8(input logic [7:0] w);
    i8.load_valid = 1'b1;
    i8.data_in = w;
    wait_acc8();
    i8.load_valid = 1'b0;
    i8.data_in = 8'($urandom);
  endtask
  task automatic send4(input logic [3:0] w);
    i4.load_valid = 1'b1;
    i4.data_in = w;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (i4.load_ready) begin
        @(posedge clk);
        #1;
        i4.load_valid = 1'b0;
        return;
      end
    end
    chk("w4_accept_timeout", 0, 1);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    i8.load_valid = 1'b0;
    i8.data_in = '0;
    i4.load_valid = 1'b0;
    i4.data_in = '0;
    idle(3);
    rst = 1'b0;
    idle(5);
    chk("reset_ready", {i8.load_ready, i8.busy, i8.bit_valid, i8.frame_clr, i8.bit_out}, 5'b10000);
    send8(8'hB4);
    idle(12);
    i8.load_valid = 1'b1;
    i8.data_in = 8'hFF;
    wait_acc8();
    i8.data_in = 8'h07;
    wait_acc8();
    i8.load_valid = 1'b0;
    idle(12);
    send8(8'h5A);
    repeat (3) begin
      idle(1);
      i8.load_valid = 1'($urandom);
      i8.data_in = 8'($urandom);
    end
    i8.load_valid = 1'b0;
    idle(10);
    send8(8'hA5);
    idle(5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", {i8.bit_valid, i8.load_ready, i8.busy}, 3'b010);
    send8(8'h03);
    idle(12);
    for (int i = 0; i < 40; i++) begin
      i8.load_valid = 1'b1;
      i8.data_in = 8'($urandom);
      wait_acc8();
      if ($urandom_range(1, 0) == 1) begin
        i8.load_valid = 1'b0;
        idle($urandom_range(11, 0));
      end
    end
    i8.load_valid = 1'b0;
    idle(12);
    send4(4'hC);
    idle(8);
    for (int i = 0; i < 10; i++) begin
      send4(4'($urandom));
      idle($urandom_range(6, 0));
    end
    idle(20);
    chk("w8_queue_drained", q8.size(), 0);
    chk("w4_queue_drained", q4.size(), 0);
    chk("w8_frame_closed", act8, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
